mod_ctrl: RTL and testbench

MOD_CTRL -- requirements
Module: mod_ctrl

---
 rtl/mod_ctrl.sv | 138 +++++++++++++
 tb/tb_mod_ctrl.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/mod_ctrl.sv
// Sequencing controller for an iterative "a mod b" datapath: latches operands,
// issues load/compare/subtract/assign/finish strobes and reports the remainder.
`timescale 1ns/1ps

// state | meaning
// IDLE  | waiting for start; accepts a new operation (also during the valid cycle)
// LOAD  | asg_tempp: datapath loads temp from a_op
// COMP  | make_comp: datapath registers temp < b
// CHK   | decide: finish, subtract again, or give up on timeout
// SUB   | make_sub: datapath computes temp - b; iteration counted here
// ASG   | make_asg: datapath writes the difference back to temp
// FIN   | done: datapath presents temp on result_dp next cycle
// CAPT  | register result_dp and raise valid
module mod_ctrl #(
   parameter int MAX_ITER = 1024
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        start,
   input  logic [31:0] a_in,
   input  logic [31:0] b_in,
   input  logic        lt,
   input  logic [31:0] result_dp,
   output logic [31:0] a_op,
   output logic [31:0] b_op,
   output logic        asg_tempp,
   output logic        make_sub,
   output logic        make_asg,
   output logic        make_comp,
   output logic        done,
   output logic        busy,
   output logic        valid,
   output logic [31:0] result,
   output logic        err_div0,
   output logic        err_timeout,
   output logic [31:0] iter_cnt
);

   typedef enum logic [2:0] {
      IDLE, LOAD, COMP, CHK, SUB, ASG, FIN, CAPT
   } state_t;

   localparam logic [31:0] ITER_LIMIT = 32'(MAX_ITER);

   state_t state, state_nxt;
   logic   div0_req;
   logic   limit_hit;

   assign div0_req  = start && (b_in == 32'd0);
   assign limit_hit = (iter_cnt >= ITER_LIMIT);

   always_comb begin
      state_nxt = state;
      asg_tempp = 1'b0;
      make_comp = 1'b0;
      make_sub  = 1'b0;
      make_asg  = 1'b0;
      done      = 1'b0;
      busy      = (state != IDLE);
      case (state)
         IDLE: if (start && !div0_req) state_nxt = LOAD;
         LOAD: begin
            asg_tempp = 1'b1;
            state_nxt = COMP;
         end
         COMP: begin
            make_comp = 1'b1;
            state_nxt = CHK;
         end
         CHK: begin
            if (lt)              state_nxt = FIN;
            else if (!limit_hit) state_nxt = SUB;
            else                 state_nxt = IDLE;
         end
         SUB: begin
            make_sub  = 1'b1;
            state_nxt = ASG;
         end
         ASG: begin
            make_asg  = 1'b1;
            state_nxt = COMP;
         end
         FIN: begin
            done      = 1'b1;
            state_nxt = CAPT;
         end
         CAPT:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // valid and the error flags are single-cycle pulses; everything else holds.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state       <= IDLE;
         a_op        <= '0;
         b_op        <= '0;
         result      <= '0;
         iter_cnt    <= '0;
         valid       <= 1'b0;
         err_div0    <= 1'b0;
         err_timeout <= 1'b0;
      end else begin
         state       <= state_nxt;
         valid       <= 1'b0;
         err_div0    <= 1'b0;
         err_timeout <= 1'b0;
         case (state)
            IDLE: begin
               if (div0_req) begin
                  valid    <= 1'b1;
                  err_div0 <= 1'b1;
                  result   <= '0;
                  iter_cnt <= '0;
               end else if (start) begin
                  a_op     <= a_in;
                  b_op     <= b_in;
                  iter_cnt <= '0;
               end
            end
            CHK: begin
               if (!lt && limit_hit) begin
                  valid       <= 1'b1;
                  err_timeout <= 1'b1;
                  result      <= '0;
               end
            end
            SUB:  iter_cnt <= iter_cnt + 32'd1;
            CAPT: begin
               result <= result_dp;
               valid  <= 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mod_ctrl.sv
// Self-checking bench for mod_ctrl: two instances (MAX_ITER 16 and 4) driven by
// directed and random operations, checked against an arithmetic reference.
`timescale 1ns/1ps

module tb_mod_ctrl;

   localparam int MAX0   = 16;
   localparam int MAX1   = 4;
   localparam int LIM    = 200;
   localparam int C_LOAD = 1, C_COMP = 2, C_SUB = 3, C_ASG = 4, C_FIN = 5;

   logic        clk = 1'b0;
   logic        rst;
   logic        start_s [2];
   logic [31:0] a_in, b_in;
   logic        lt_s    [2];
   logic [31:0] rdp     [2];
   logic [31:0] a_op    [2];
   logic [31:0] b_op    [2];
   logic        asg_tempp [2];
   logic        make_sub  [2];
   logic        make_asg  [2];
   logic        make_comp [2];
   logic        done      [2];
   logic        busy      [2];
   logic        valid     [2];
   logic [31:0] result    [2];
   logic        err_div0  [2];
   logic        err_timeout [2];
   logic [31:0] iter_cnt  [2];

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   mod_ctrl #(.MAX_ITER(MAX0)) dut0 (
      .CLK(clk), .RST(rst), .start(start_s[0]), .a_in(a_in), .b_in(b_in),
      .lt(lt_s[0]), .result_dp(rdp[0]), .a_op(a_op[0]), .b_op(b_op[0]),
      .asg_tempp(asg_tempp[0]), .make_sub(make_sub[0]), .make_asg(make_asg[0]),
      .make_comp(make_comp[0]), .done(done[0]), .busy(busy[0]), .valid(valid[0]),
      .result(result[0]), .err_div0(err_div0[0]), .err_timeout(err_timeout[0]),
      .iter_cnt(iter_cnt[0]));

   mod_ctrl #(.MAX_ITER(MAX1)) dut1 (
      .CLK(clk), .RST(rst), .start(start_s[1]), .a_in(a_in), .b_in(b_in),
      .lt(lt_s[1]), .result_dp(rdp[1]), .a_op(a_op[1]), .b_op(b_op[1]),
      .asg_tempp(asg_tempp[1]), .make_sub(make_sub[1]), .make_asg(make_asg[1]),
      .make_comp(make_comp[1]), .done(done[1]), .busy(busy[1]), .valid(valid[1]),
      .result(result[1]), .err_div0(err_div0[1]), .err_timeout(err_timeout[1]),
      .iter_cnt(iter_cnt[1]));

   // behavioural datapath: temp register, registered compare, result on done
   logic [31:0] temp [2];
   logic [31:0] diff [2];
   always @(posedge clk) begin
      for (int i = 0; i < 2; i++) begin
         if (asg_tempp[i]) temp[i] <= a_op[i];
         if (make_sub[i])  diff[i] <= temp[i] - b_op[i];
         if (make_asg[i])  temp[i] <= diff[i];
         if (make_comp[i]) lt_s[i] <= (temp[i] < b_op[i]);
         if (done[i])      rdp[i]  <= temp[i];
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] out_bits(input int i);
      return a_op[i] | b_op[i] | result[i] | iter_cnt[i] |
             {23'd0, asg_tempp[i], make_sub[i], make_asg[i], make_comp[i],
              done[i], busy[i], valid[i], err_div0[i], err_timeout[i]};
   endfunction

   // Called at a negedge; returns at the negedge on which valid is seen.
   task automatic run_op(input int idx, input logic [31:0] a, input logic [31:0] b,
                         input bit hold);
      int maxi, k, edges, nsub, busy_bad, op_bad, flag_bad, multi_bad, order_bad;
      logic [31:0] e_res, e_iter;
      bit e_d0, e_to;
      int e_lat;
      int exp_seq[$];
      int obs_seq[$];
      maxi = (idx == 0) ? MAX0 : MAX1;
      e_d0 = 0; e_to = 0;
      if (b == 0) begin
         e_res = 0; e_d0 = 1; e_iter = 0; e_lat = 1;
      end else begin
         k = int'(a / b);
         if (k > maxi) begin
            e_res = 0; e_to = 1; e_iter = 32'(maxi); e_lat = 4 + 4 * maxi;
            k = maxi;
         end else begin
            e_res = a % b; e_iter = 32'(k); e_lat = 6 + 4 * k;
         end
         exp_seq.push_back(C_LOAD);
         exp_seq.push_back(C_COMP);
         for (int j = 0; j < k; j++) begin
            exp_seq.push_back(C_SUB);
            exp_seq.push_back(C_ASG);
            exp_seq.push_back(C_COMP);
         end
         if (!e_to) exp_seq.push_back(C_FIN);
      end
      nsub = 0; busy_bad = 0; op_bad = 0; flag_bad = 0; multi_bad = 0;
      start_s[idx] = 1'b1; a_in = a; b_in = b;
      @(posedge clk); edges = 1;
      @(negedge clk);
      if (!hold) start_s[idx] = 1'b0;
      while (!valid[idx] && edges < LIM) begin
         if (busy[idx] !== !e_d0) busy_bad++;
         if (!e_d0 && (a_op[idx] !== a || b_op[idx] !== b)) op_bad++;
         if (err_div0[idx] || err_timeout[idx]) flag_bad++;
         if (int'(asg_tempp[idx]) + int'(make_comp[idx]) + int'(make_sub[idx]) +
             int'(make_asg[idx]) + int'(done[idx]) > 1) multi_bad++;
         if (asg_tempp[idx]) obs_seq.push_back(C_LOAD);
         if (make_comp[idx]) obs_seq.push_back(C_COMP);
         if (make_sub[idx]) begin obs_seq.push_back(C_SUB); nsub++; end
         if (make_asg[idx])  obs_seq.push_back(C_ASG);
         if (done[idx])      obs_seq.push_back(C_FIN);
         @(posedge clk); edges++;
         @(negedge clk);
      end
      order_bad = (obs_seq.size() > exp_seq.size()) ? obs_seq.size() - exp_seq.size()
                                                    : exp_seq.size() - obs_seq.size();
      for (int j = 0; j < obs_seq.size() && j < exp_seq.size(); j++)
         if (obs_seq[j] != exp_seq[j]) order_bad++;
      check("valid",       32'(valid[idx]), 32'd1);
      check("latency",     32'(edges), 32'(e_lat));
      check("result",      result[idx], e_res);
      check("err_div0",    32'(err_div0[idx]), 32'(e_d0));
      check("err_timeout", 32'(err_timeout[idx]), 32'(e_to));
      check("iter_cnt",    iter_cnt[idx], e_iter);
      check("sub_count",   32'(nsub), e_iter);
      check("strobe_order", 32'(order_bad), 32'd0);
      check("strobe_onehot", 32'(multi_bad), 32'd0);
      check("busy_during", 32'(busy_bad), 32'd0);
      check("busy_at_valid", 32'(busy[idx]), 32'd0);
      check("operands_stable", 32'(op_bad), 32'd0);
      check("flags_without_valid", 32'(flag_bad), 32'd0);
   endtask

   initial begin
      #2ms;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      int idx, prev_idx, waited;
      bit hold, prev_hold;
      logic [31:0] ra, rb;
      rst = 1'b1; start_s[0] = 1'b0; start_s[1] = 1'b0; a_in = '0; b_in = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset_outputs0", out_bits(0), 32'd0);
      check("reset_outputs1", out_bits(1), 32'd0);
      rst = 1'b0;

      run_op(0, 32'd7, 32'd3, 1'b0);
      run_op(0, 32'd2, 32'd5, 1'b0);
      run_op(0, 32'd9, 32'd0, 1'b0);
      run_op(1, 32'd100, 32'd1, 1'b0);
      run_op(1, 32'd9, 32'd2, 1'b0);

      // start held high: the next op must launch from the valid cycle
      run_op(0, 32'd7, 32'd3, 1'b1);
      run_op(0, 32'd2, 32'd5, 1'b0);

      // abort mid-subtract, then restart right after reset release
      start_s[0] = 1'b1; a_in = 32'd50; b_in = 32'd7;
      @(posedge clk);
      @(negedge clk);
      start_s[0] = 1'b0;
      waited = 0;
      while (!make_sub[0] && waited < LIM) begin
         @(negedge clk); waited++;
      end
      check("reached_sub", 32'(make_sub[0]), 32'd1);
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("abort_outputs", out_bits(0), 32'd0);
      rst = 1'b0;
      run_op(0, 32'd50, 32'd7, 1'b0);

      prev_hold = 0; prev_idx = 0;
      for (int n = 0; n < 24; n++) begin
         idx  = prev_hold ? prev_idx : int'($urandom_range(0, 1));
         rb   = 32'($urandom_range(0, 12));
         ra   = 32'($urandom_range(0, int'(rb) * 20 + 3));
         hold = (n < 23) && ($urandom_range(0, 3) == 0);
         run_op(idx, ra, rb, hold);
         prev_hold = hold; prev_idx = idx;
      end
      start_s[0] = 1'b0; start_s[1] = 1'b0;

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
